match_controller: RTL and testbench

- Sequences a full match around the ball controller: idle, serve countdown, play, post-goal pause, game over.
- Drives the ball controller's game_initiated and game_over inputs, and consumes its blue/red score toggles.
- Keeps the scores, decides the winner and exposes state and countdown for the VGA overlay.
- Sits in game_controller between the input/debounce logic and the ball and player controllers.

---
 rtl/match_controller.sv | 139 +++++++++++++
 tb/tb_match_controller.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// match_controller: match sequencer (idle/countdown/play/goal pause/over) around the ball controller; MATCH_TIMER_EN adds a match timer
module match_controller #(
  parameter int WIN_SCORE     = 5,
  parameter int TICKS_PER_SEC = 25000000,
  parameter int PAUSE_CYCLES  = 50000000,
  parameter int MATCH_SECONDS = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       blue_score_toggle,
  input  logic       red_score_toggle,
  output logic       game_initiated,
  output logic       game_over,
  output logic [3:0] blue_score,
  output logic [3:0] red_score,
  output logic [1:0] winner,
  output logic [1:0] countdown,
  output logic [2:0] match_state,
  output logic [7:0] time_left
);
  localparam int SW = $clog2(TICKS_PER_SEC);
  localparam int PW = $clog2(PAUSE_CYCLES + 1);
`ifdef MATCH_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif
  localparam logic [7:0] TL_LOAD = TIMER_EN ? 8'(MATCH_SECONDS) : 8'd0;
  typedef enum logic [2:0] {IDLE, COUNTDOWN, PLAY, GOAL_PAUSE, OVER} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] sec_q, sec_d;
  logic [PW-1:0] pause_q, pause_d;
  logic [3:0] blue_q, blue_d, red_q, red_d, nb, nr;
  logic [1:0] win_q, win_d, cd_q, cd_d;
  logic [7:0] tl_q, tl_d;
  logic init_q, init_d, over_q, over_d;
  logic start_prev_q, blue_prev_q, red_prev_q;
  logic start_edge, goal_b, goal_r, wrap, win_b, win_r, expire;
  always_comb begin
    start_edge = start_btn & ~start_prev_q;
    goal_b = blue_score_toggle ^ blue_prev_q;
    goal_r = red_score_toggle ^ red_prev_q;
    wrap = sec_q == SW'(TICKS_PER_SEC - 1);
    nb = blue_q + {3'd0, goal_b};
    nr = red_q + {3'd0, goal_r};
    win_b = nb == 4'(WIN_SCORE);
    win_r = nr == 4'(WIN_SCORE);
    state_d = state_q;
    sec_d = wrap ? '0 : sec_q + 1'b1;
    pause_d = pause_q;
    blue_d = blue_q;
    red_d = red_q;
    win_d = win_q;
    cd_d = cd_q;
    tl_d = tl_q;
`ifdef MATCH_TIMER_EN
    expire = wrap && tl_q == 8'd1 && (state_q == PLAY || state_q == GOAL_PAUSE);
    if (wrap && (state_q == PLAY || state_q == GOAL_PAUSE)) tl_d = tl_q - 8'd1;
`else
    expire = 1'b0;
`endif
    case (state_q)
      IDLE, OVER: if (start_edge) begin
        state_d = COUNTDOWN;
        blue_d = '0;
        red_d = '0;
        win_d = '0;
        cd_d = 2'd3;
        sec_d = '0;
        tl_d = TL_LOAD;
      end
      COUNTDOWN: if (wrap) begin
        cd_d = cd_q - 2'd1;
        state_d = cd_q == 2'd1 ? PLAY : COUNTDOWN;
      end
      PLAY: begin
        blue_d = nb;
        red_d = nr;
        if (win_b || win_r) begin
          state_d = OVER;
          win_d = {win_r, win_b};
        end else if (expire) begin
          state_d = OVER;
          win_d = nb > nr ? 2'd1 : nr > nb ? 2'd2 : 2'd3;
        end else if (goal_b || goal_r) begin
          state_d = GOAL_PAUSE;
          pause_d = PW'(PAUSE_CYCLES - 1);
        end
      end
      GOAL_PAUSE: begin
        if (expire) begin
          state_d = OVER;
          win_d = blue_q > red_q ? 2'd1 : red_q > blue_q ? 2'd2 : 2'd3;
        end else if (pause_q == '0) state_d = PLAY;
        else pause_d = pause_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    over_d = state_d == IDLE || state_d == OVER;
    init_d = state_d == PLAY && state_q != PLAY;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sec_q <= '0;
      pause_q <= '0;
      blue_q <= '0;
      red_q <= '0;
      win_q <= '0;
      cd_q <= '0;
      tl_q <= '0;
      init_q <= 1'b0;
      over_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sec_q <= sec_d;
      pause_q <= pause_d;
      blue_q <= blue_d;
      red_q <= red_d;
      win_q <= win_d;
      cd_q <= cd_d;
      tl_q <= tl_d;
      init_q <= init_d;
      over_q <= over_d;
    end
    start_prev_q <= start_btn;
    blue_prev_q <= blue_score_toggle;
    red_prev_q <= red_score_toggle;
  end
  assign game_initiated = init_q;
  assign game_over = over_q;
  assign blue_score = blue_q;
  assign red_score = red_q;
  assign winner = win_q;
  assign countdown = cd_q;
  assign match_state = state_q;
  assign time_left = tl_q;
endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller: directed plus random stimulus against a cycle-count reference model
module tb_match_controller;
  localparam int W = 3, T = 4, P = 5, MS = 2;
`ifdef MATCH_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start_btn = 1'b0, blue_t = 1'b0, red_t = 1'b0;
  logic game_initiated, game_over;
  logic [3:0] blue_score, red_score;
  logic [1:0] winner, countdown;
  logic [2:0] match_state;
  logic [7:0] time_left;
  int checks = 0, errors = 0;
  int n = 0, ms = 0, mb = 0, mr = 0, mw = 0, minit = 0, mtl = 0, t0 = 0, p_end = 0;
  bit p_s = 1'b0, p_b = 1'b0, p_r = 1'b0;
  match_controller #(.WIN_SCORE(W), .TICKS_PER_SEC(T), .PAUSE_CYCLES(P), .MATCH_SECONDS(MS)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn),
    .blue_score_toggle(blue_t), .red_score_toggle(red_t),
    .game_initiated(game_initiated), .game_over(game_over),
    .blue_score(blue_score), .red_score(red_score), .winner(winner),
    .countdown(countdown), .match_state(match_state), .time_left(time_left)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, n);
    end
  endtask
  function automatic int lead(input int b, input int r);
    return b > r ? 1 : r > b ? 2 : 3;
  endfunction
  task automatic step();
    bit se, gb, gr, expired;
    int tl;
    @(posedge clk);
    n++;
    se = start_btn && !p_s;
    gb = blue_t ^ p_b;
    gr = red_t ^ p_r;
    tl = MS - (n - t0 - 3 * T) / T;
    expired = TIMER && tl == 0;
    minit = 0;
    if (reset) begin
      ms = 0; mb = 0; mr = 0; mw = 0; mtl = 0;
    end else begin
      case (ms)
        0, 4: if (se) begin
          ms = 1; mb = 0; mr = 0; mw = 0; t0 = n;
          mtl = TIMER ? MS : 0;
        end
        1: if (n - t0 == 3 * T) begin ms = 2; minit = 1; end
        2: begin
          mb += int'(gb);
          mr += int'(gr);
          if (TIMER) mtl = tl;
          if (mb == W || mr == W) begin
            ms = 4;
            mw = (mb == W ? 1 : 0) + (mr == W ? 2 : 0);
          end else if (expired) begin
            ms = 4; mw = lead(mb, mr);
          end else if (gb || gr) begin
            ms = 3; p_end = n + P;
          end
        end
        3: begin
          if (TIMER) mtl = tl;
          if (expired) begin ms = 4; mw = lead(mb, mr); end
          else if (n == p_end) begin ms = 2; minit = 1; end
        end
        default: ms = 0;
      endcase
    end
    p_s = start_btn;
    p_b = blue_t;
    p_r = red_t;
    #1;
    chk("state", match_state, ms);
    chk("blue_score", blue_score, mb);
    chk("red_score", red_score, mr);
    chk("winner", winner, mw);
    chk("countdown", countdown, ms == 1 ? 3 - (n - t0) / T : 0);
    chk("game_over", game_over, (ms == 0 || ms == 4) ? 1 : 0);
    chk("game_initiated", game_initiated, minit);
    chk("time_left", time_left, mtl);
  endtask
  task automatic cyc(input int k);
    repeat (k) step();
  endtask
  task automatic start_match();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    cyc(13);
  endtask
  task automatic goal(input bit b, input bit r, input int wait_cycles);
    if (b) blue_t = ~blue_t;
    if (r) red_t = ~red_t;
    step();
    cyc(wait_cycles);
  endtask
  initial begin
    cyc(2);
    reset = 1'b0;
    cyc(2);
    start_match();
    goal(1, 0, 2);
    goal(0, 1, 4);
    goal(1, 0, 7);
    goal(1, 0, 3);
    goal(1, 0, 3);
    start_match();
    goal(1, 0, 7);
    goal(0, 1, 7);
    goal(1, 0, 7);
    goal(0, 1, 7);
    goal(1, 1, 3);
    start_match();
    goal(1, 0, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    cyc(2);
    start_match();
    cyc(2);
    goal(1, 0, 7);
    cyc(12);
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 299) == 0;
      if ($urandom_range(0, 9) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 5) == 0) blue_t = ~blue_t;
      if ($urandom_range(0, 5) == 0) red_t = ~red_t;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
